// File: rtl/ws2812_serializer.sv
// WS2812 one-wire serializer: fetches GRB words from pixel RAM and shapes pixel_bit_counter timing
// into DOUT. Define WS2812_BRIGHTNESS_EN to add the BRIGHT input with per-channel (ch*BRIGHT)>>8 scaling.
module ws2812_serializer #(
    parameter int PIXELS       = 256,
    parameter int BITS         = 24,
    parameter int NSS          = 64,
    parameter int T0H          = 20,
    parameter int T1H          = 41,
    parameter int LATCH_CYCLES = 15360
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]  bright_i,
`endif
    input  logic [7:0]  pixel_i,
    input  logic [7:0]  bit_i,
    input  logic [7:0]  ns_i,
    input  logic        done_i,
    output logic        cnt_rst_o,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_o,
    input  logic [23:0] rd_data_i,
    output logic        dout_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    // state  | meaning
    // IDLE   | counter held in reset, DOUT low, waiting for START
    // PRIME  | pixel 0 being fetched, counter still held in reset
    // STREAM | counter running, DOUT shaped from NS and the current MSB
    // LATCH  | DOUT low for the latch period, then one FRAME_DONE pulse
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_LATCH  = 2'd3;

    localparam logic [7:0] NS_LAST  = 8'(NSS - 1);
    localparam logic [7:0] BIT_LAST = 8'(BITS - 1);
    localparam logic [7:0] PIX_LAST = 8'(PIXELS - 1);
    localparam logic [7:0] T0H_W    = 8'(T0H);
    localparam logic [7:0] T1H_W    = 8'(T1H);

    localparam int              LW         = $clog2(LATCH_CYCLES + 1);
    localparam logic [LW-1:0]   LATCH_LOAD = LW'(LATCH_CYCLES);

`ifdef WS2812_BRIGHTNESS_EN
    localparam logic [1:0] PRIME_LAST = 2'd2;

    function automatic logic [23:0] scale(input logic [23:0] w, input logic [7:0] b);
        logic [15:0] g;
        logic [15:0] r;
        logic [15:0] bl;
        g  = 16'(w[23:16]) * 16'(b);
        r  = 16'(w[15:8])  * 16'(b);
        bl = 16'(w[7:0])   * 16'(b);
        return {g[15:8], r[15:8], bl[15:8]};
    endfunction
`else
    localparam logic [1:0] PRIME_LAST = 2'd1;
`endif

    logic [1:0]    state_q,      state_d;
    logic [1:0]    prime_cnt_q,  prime_cnt_d;
    logic [LW-1:0] latch_cnt_q,  latch_cnt_d;
    logic [23:0]   shreg_q,      shreg_d;
    logic [23:0]   next_word_q,  next_word_d;
    logic          cnt_rst_q,    cnt_rst_d;
    logic          rd_en_q,      rd_en_d;
    logic [7:0]    rd_addr_q,    rd_addr_d;
    logic          dout_q,       dout_d;
    logic          busy_q,       busy_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        latch_cnt_d  = latch_cnt_q;
        shreg_d      = shreg_q;
        next_word_d  = next_word_q;
        cnt_rst_d    = cnt_rst_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        dout_d       = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_rst_d = 1'b1;
                busy_d    = 1'b0;
                // A START landing in the FRAME_DONE cycle is dropped; a clean IDLE cycle comes first.
                if (start_i && !frame_done_q) begin
                    state_d     = S_PRIME;
                    prime_cnt_d = 2'd0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = 8'd0;
                    busy_d      = 1'b1;
                end
            end

            S_PRIME: begin
                prime_cnt_d = prime_cnt_q + 2'd1;
                if (prime_cnt_q == 2'd1) begin
                    shreg_d = rd_data_i;
                end
`ifdef WS2812_BRIGHTNESS_EN
                if (prime_cnt_q == 2'd2) begin
                    shreg_d = scale(shreg_q, bright_i);
                end
`endif
                if (prime_cnt_q == PRIME_LAST) begin
                    cnt_rst_d = 1'b0;
                    state_d   = S_STREAM;
                end
            end

            S_STREAM: begin
                dout_d = (ns_i < (shreg_q[23] ? T1H_W : T0H_W));
                if (bit_i == 8'd0 && ns_i == 8'd0 && pixel_i != PIX_LAST) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = pixel_i + 8'd1;
                end
                // Prefetched word is captured once per pixel, two ticks after the read strobe.
                if (bit_i == 8'd0 && ns_i == 8'd2) begin
                    next_word_d = rd_data_i;
                end
`ifdef WS2812_BRIGHTNESS_EN
                if (bit_i == 8'd0 && ns_i == 8'd3) begin
                    next_word_d = scale(next_word_q, bright_i);
                end
`endif
                if (ns_i == NS_LAST) begin
                    if (bit_i == BIT_LAST) begin
                        shreg_d = next_word_q;
                    end else begin
                        shreg_d = {shreg_q[22:0], 1'b0};
                    end
                end
                if (done_i && bit_i == BIT_LAST && ns_i == NS_LAST) begin
                    cnt_rst_d   = 1'b1;
                    state_d     = S_LATCH;
                    latch_cnt_d = LATCH_LOAD;
                end
            end

            S_LATCH: begin
                if (latch_cnt_q == '0) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q - LW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            prime_cnt_q  <= 2'd0;
            latch_cnt_q  <= '0;
            shreg_q      <= 24'd0;
            next_word_q  <= 24'd0;
            cnt_rst_q    <= 1'b1;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= 8'd0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prime_cnt_q  <= prime_cnt_d;
            latch_cnt_q  <= latch_cnt_d;
            shreg_q      <= shreg_d;
            next_word_q  <= next_word_d;
            cnt_rst_q    <= cnt_rst_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cnt_rst_o    = cnt_rst_q;
    assign rd_en_o      = rd_en_q;
    assign rd_addr_o    = rd_addr_q;
    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: two instances (1 and 4 pixels), each with a pixel/bit/tick counter
// model and a 1-cycle RAM; DOUT is decoded back into bits and compared against a word-level model.
module tb_ws2812_serializer;

    localparam int L1  = 15360;
    localparam int L4  = 200;
    localparam int T0H = 20;
    localparam int T1H = 41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start4 = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright = 8'hFF;
`endif
    logic [23:0] mem [0:3];

    logic        d1_cnt_rst, d1_rd_en, d1_dout, d1_busy, d1_fd;
    logic [7:0]  d1_rd_addr;
    logic [23:0] d1_rd_data = 24'd0;
    logic        d4_cnt_rst, d4_rd_en, d4_dout, d4_busy, d4_fd;
    logic [7:0]  d4_rd_addr;
    logic [23:0] d4_rd_data = 24'd0;

    logic [7:0] c1_pix = 8'd0, c1_bit = 8'd0, c1_ns = 8'd0;
    logic [7:0] c4_pix = 8'd0, c4_bit = 8'd0, c4_ns = 8'd0;
    logic       c1_done, c4_done;

    ws2812_serializer #(.PIXELS(1), .LATCH_CYCLES(L1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
`ifdef WS2812_BRIGHTNESS_EN
        .bright_i(bright),
`endif
        .pixel_i(c1_pix), .bit_i(c1_bit), .ns_i(c1_ns), .done_i(c1_done),
        .cnt_rst_o(d1_cnt_rst), .rd_en_o(d1_rd_en), .rd_addr_o(d1_rd_addr), .rd_data_i(d1_rd_data),
        .dout_o(d1_dout), .busy_o(d1_busy), .frame_done_o(d1_fd)
    );

    ws2812_serializer #(.PIXELS(4), .LATCH_CYCLES(L4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4),
`ifdef WS2812_BRIGHTNESS_EN
        .bright_i(bright),
`endif
        .pixel_i(c4_pix), .bit_i(c4_bit), .ns_i(c4_ns), .done_i(c4_done),
        .cnt_rst_o(d4_cnt_rst), .rd_en_o(d4_rd_en), .rd_addr_o(d4_rd_addr), .rd_data_i(d4_rd_data),
        .dout_o(d4_dout), .busy_o(d4_busy), .frame_done_o(d4_fd)
    );

    // pixel_bit_counter stand-ins: NS counts 0..63, then BIT 0..23, then PIXEL (wrapping)
    always @(posedge clk) begin
        if (d1_cnt_rst) begin
            c1_pix <= 8'd0; c1_bit <= 8'd0; c1_ns <= 8'd0;
        end else if (c1_ns == 8'd63) begin
            c1_ns <= 8'd0;
            if (c1_bit == 8'd23) begin
                c1_bit <= 8'd0;
                c1_pix <= 8'd0;
            end else c1_bit <= c1_bit + 8'd1;
        end else c1_ns <= c1_ns + 8'd1;
    end
    assign c1_done = (c1_pix == 8'd0) && (c1_bit == 8'd23);

    always @(posedge clk) begin
        if (d4_cnt_rst) begin
            c4_pix <= 8'd0; c4_bit <= 8'd0; c4_ns <= 8'd0;
        end else if (c4_ns == 8'd63) begin
            c4_ns <= 8'd0;
            if (c4_bit == 8'd23) begin
                c4_bit <= 8'd0;
                c4_pix <= (c4_pix == 8'd3) ? 8'd0 : c4_pix + 8'd1;
            end else c4_bit <= c4_bit + 8'd1;
        end else c4_ns <= c4_ns + 8'd1;
    end
    assign c4_done = (c4_pix == 8'd3) && (c4_bit == 8'd23);

    always @(posedge clk) begin
        if (d1_rd_en) d1_rd_data <= mem[d1_rd_addr[1:0]];
        if (d4_rd_en) d4_rd_data <= mem[d4_rd_addr[1:0]];
    end

    // monitor on the selected instance
    logic sel = 1'b0;
    logic       m_dout, m_rd_en, m_cnt_rst, m_fd;
    logic [7:0] m_rd_addr, m_pix, m_bit, m_ns, m_last;
    assign m_dout    = sel ? d4_dout    : d1_dout;
    assign m_rd_en   = sel ? d4_rd_en   : d1_rd_en;
    assign m_rd_addr = sel ? d4_rd_addr : d1_rd_addr;
    assign m_cnt_rst = sel ? d4_cnt_rst : d1_cnt_rst;
    assign m_fd      = sel ? d4_fd      : d1_fd;
    assign m_pix     = sel ? c4_pix     : c1_pix;
    assign m_bit     = sel ? c4_bit     : c1_bit;
    assign m_ns      = sel ? c4_ns      : c1_ns;
    assign m_last    = sel ? 8'd3       : 8'd0;

    int hw_q[$];
    int per_q[$];
    int addr_q[$];
    int fd_count = 0, fd_low = 0, hi_run = 0, since_rise = 0, low_run = 0;
    int cr_rises = 0, cr_bad = 0, wrap_bad = 0, rst_hi_bad = 0;
    bit have_rise = 1'b0;
    logic prev_dout = 1'b0, prev_cr = 1'b1;
    logic [7:0] p_pix = 8'd0, p_bit = 8'd0, p_ns = 8'd0;

    always @(negedge clk) begin
        if (m_fd) begin
            fd_count++;
            fd_low = low_run;
        end
        if (m_dout && !prev_dout) begin
            if (have_rise) per_q.push_back(since_rise);
            since_rise = 0;
            have_rise = 1'b1;
            hi_run = 0;
        end
        if (have_rise) since_rise++;
        if (m_dout) begin
            hi_run++;
            low_run = 0;
        end else low_run++;
        if (!m_dout && prev_dout) hw_q.push_back(hi_run);
        if (m_rd_en) addr_q.push_back(int'(m_rd_addr));
        if (m_cnt_rst && !prev_cr) begin
            cr_rises++;
            if (!(p_pix == m_last && p_bit == 8'd23 && p_ns == 8'd63)) cr_bad++;
        end
        if (!m_cnt_rst && !prev_cr && m_pix < p_pix) wrap_bad++;
        if (m_dout && m_cnt_rst) rst_hi_bad++;
        prev_dout = m_dout;
        prev_cr = m_cnt_rst;
        p_pix = m_pix; p_bit = m_bit; p_ns = m_ns;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] model_word(input logic [23:0] w);
`ifdef WS2812_BRIGHTNESS_EN
        int g, r, b;
        g = (int'(w[23:16]) * int'(bright)) / 256;
        r = (int'(w[15:8])  * int'(bright)) / 256;
        b = (int'(w[7:0])   * int'(bright)) / 256;
        return {8'(g), 8'(r), 8'(b)};
`else
        return w;
`endif
    endfunction

    function automatic logic [95:0] model_frame(input logic [95:0] words, input int npix);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < npix; i++) r = {r[71:0], model_word(words[95-24*i -: 24])};
        return r;
    endfunction

    task automatic clear_mon();
        hw_q.delete(); per_q.delete(); addr_q.delete();
        fd_count = 0; have_rise = 1'b0; cr_rises = 0; cr_bad = 0; wrap_bad = 0; rst_hi_bad = 0;
    endtask

    task automatic run_frame(input bit s, input logic [95:0] words, input int npix,
                             output logic [95:0] dec);
        int n, bad, lat;
        sel = s;
        for (int i = 0; i < 4; i++) mem[i] = words[95-24*i -: 24];
        clear_mon();
        if (s) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start1 = 1'b0;
        n = 0;
        while (fd_count == 0 && n < 40000) begin
            @(posedge clk); #1; n++;
        end
        chk("frame_done_seen", fd_count, 1);
        dec = '0; bad = 0;
        foreach (hw_q[i]) begin
            dec = {dec[94:0], hw_q[i] == T1H};
            if (hw_q[i] != T0H && hw_q[i] != T1H) bad++;
        end
        chk("bit_count", hw_q.size(), npix * 24);
        chk("bad_high_widths", bad, 0);
        chk("decoded_bits", dec, model_frame(words, npix));
        bad = 0;
        foreach (per_q[i]) if (per_q[i] != 64) bad++;
        chk("period_count", per_q.size(), npix * 24 - 1);
        chk("bad_periods", bad, 0);
        lat = s ? L4 : L1;
        if (hw_q.size() > 0) chk("latch_low", fd_low, 64 - hw_q[hw_q.size()-1] + lat);
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] != i) bad++;
        chk("rd_count", addr_q.size(), npix);
        chk("rd_addr_seq", bad, 0);
        chk("cnt_rst_rises", cr_rises, 1);
        chk("cnt_rst_rise_pos", cr_bad, 0);
        chk("pixel_wrap", wrap_bad, 0);
        chk("dout_high_in_reset", rst_hi_bad, 0);
    endtask

    typedef struct {
        logic [95:0] words;
        int          exp_ones;
    } vec_t;

    vec_t vecs [2];

    initial begin
        logic [95:0] dec;
        logic [95:0] w;
        int n;
        vecs[0] = '{words: {24'h000000, 24'hFFFFFF, 24'hAAAAAA, 24'h555555}, exp_ones: 48};
        vecs[1] = '{words: {24'h800000, 24'h000001, 24'h0F0F0F, 24'hFFFF00}, exp_ones: 30};
        for (int i = 0; i < 4; i++) mem[i] = 24'd0;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_cnt_rst", {d4_cnt_rst, d1_cnt_rst}, 2'b11);
        chk("rst_rd", {d4_rd_en, d4_rd_addr}, 9'd0);
        chk("rst_dout_busy_fd", {d4_dout, d4_busy, d4_fd, d1_dout, d1_busy, d1_fd}, 6'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single pixel, MSB set
        run_frame(1'b0, {24'h800000, 72'd0}, 1, dec);
`ifndef WS2812_BRIGHTNESS_EN
        if (hw_q.size() > 0) chk("t1_first_high", hw_q[0], 41);
`endif

        for (int i = 0; i < 2; i++) begin
            run_frame(1'b1, vecs[i].words, 4, dec);
`ifndef WS2812_BRIGHTNESS_EN
            chk("vec_ones", $countones(dec), vecs[i].exp_ones);
`endif
        end

        // START held every cycle through a frame, including the FRAME_DONE cycle
        sel = 1'b1;
        clear_mon();
        start4 = 1'b1;
        n = 0;
        while (fd_count == 0 && n < 40000) begin
            @(posedge clk); #1; n++;
        end
        start4 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t3_one_frame_done", fd_count, 1);
        chk("t3_idle_after", d4_busy, 0);
        chk("t3_reads", addr_q.size(), 4);
        run_frame(1'b1, vecs[1].words, 4, dec);

        for (int r = 0; r < 2; r++) begin
            w = {$urandom(), $urandom(), $urandom()};
`ifdef WS2812_BRIGHTNESS_EN
            bright = 8'($urandom_range(0, 255));
`endif
            run_frame(1'b1, w, 4, dec);
        end

        // reset in pixel 2, bit 10
        sel = 1'b1;
        clear_mon();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (!(c4_pix == 8'd2 && c4_bit == 8'd10) && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        chk("rst_point_reached", {c4_pix, c4_bit}, {8'd2, 8'd10});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_dout", d4_dout, 0);
        chk("midrst_busy", d4_busy, 0);
        chk("midrst_cnt_rst", d4_cnt_rst, 1);
        chk("midrst_rd", {d4_rd_en, d4_rd_addr}, 9'd0);
        repeat (300) @(posedge clk);
        #1;
        chk("midrst_no_frame_done", fd_count, 0);
        chk("midrst_idle", d4_busy, 0);

`ifdef WS2812_BRIGHTNESS_EN
        bright = 8'h80;
        run_frame(1'b1, {24'hFF4002, 24'h000000, 24'hFFFFFF, 24'h123456}, 4, dec);
        chk("bright80_word0", dec[95:72], 24'h7F2001);
        bright = 8'h00;
        run_frame(1'b1, {24'hFFFFFF, 24'hFF4002, 24'h800000, 24'hABCDEF}, 4, dec);
        chk("bright0_all_zero", dec, 96'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
